// File: rtl/wb_regfile_if.sv
// -----------------------------------------------------------------------------
// wb_regfile_if
// Bundles the MEM/WB writeback inputs, the two decode-stage read ports and the
// exported writeback/debug outputs of wb_regfile.
//   master : pipeline side. It drives the writeback fields and read indices and
//            receives the read data, wbdata_out and wbcount_out.
//   slave  : register file side. It has the opposite directions.
// -----------------------------------------------------------------------------
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              regwrite_in;
  logic              memtoreg_in;
  logic [DATA_W-1:0] memres_in;
  logic [DATA_W-1:0] alures_in;
  logic [ADDR_W-1:0] writeregister_in;
  logic [ADDR_W-1:0] readreg1_in;
  logic [ADDR_W-1:0] readreg2_in;
  logic [DATA_W-1:0] readdata1_out;
  logic [DATA_W-1:0] readdata2_out;
  logic [DATA_W-1:0] wbdata_out;
  logic [31:0]       wbcount_out;

  modport master (
    output regwrite_in, memtoreg_in, memres_in, alures_in,
           writeregister_in, readreg1_in, readreg2_in,
    input  readdata1_out, readdata2_out, wbdata_out, wbcount_out
  );

  modport slave (
    input  regwrite_in, memtoreg_in, memres_in, alures_in,
           writeregister_in, readreg1_in, readreg2_in,
    output readdata1_out, readdata2_out, wbdata_out, wbcount_out
  );
endinterface

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
// Writeback stage plus the 32-entry architectural register file of the 5-stage
// MIPS pipeline.
//   clk      : pipeline clock. All state changes on its rising edge.
//   reset_n  : synchronous active-low reset. It clears every register and the
//              commit counter.
//   bus      : wb_regfile_if.slave, which carries the following signals.
//     regwrite_in / memtoreg_in / memres_in / alures_in / writeregister_in
//                : the writeback request from MEM/WB.
//     readreg1_in / readreg2_in -> readdata1_out / readdata2_out
//                : combinational read ports with same-cycle write bypass.
//     wbdata_out  : the selected writeback value. It also feeds EX forwarding.
//     wbcount_out : the number of committed writes. It wraps at 2**32.
// -----------------------------------------------------------------------------
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  wb_regfile_if.slave  bus
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] wbdata;
  logic              we;
  logic [NREGS-1:0]  wsel;
  logic [DATA_W-1:0] regs_reg [NREGS];
  logic [31:0]       wbcount_reg;
  logic [DATA_W-1:0] rd1_next;
  logic [DATA_W-1:0] rd2_next;

  // The writeback mux is valid every cycle, independent of regwrite_in.
  assign wbdata = bus.memtoreg_in ? bus.memres_in : bus.alures_in;

  // Writes to r0 are dropped here. They then neither store nor bypass nor count.
  // The && short-circuits on regwrite_in=0, so an X index cannot raise we.
  assign we = bus.regwrite_in && (bus.writeregister_in != '0);

  // This is a one-hot write decode. Bit 0 stays low because r0 is never stored.
  assign wsel[0] = 1'b0;
  for (genvar gi = 1; gi < NREGS; gi++) begin : g_wsel
    assign wsel[gi] = we && (bus.writeregister_in == ADDR_W'(gi));
  end

  // Every entry is cleared on reset, so the file is built from flops rather than RAM.
  // Entry 0 is still reset, which keeps it defined at 0.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (!reset_n) begin
        regs_reg[i] <= '0;
      end else if (wsel[i]) begin
        regs_reg[i] <= wbdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wbcount_reg <= '0;
    end else if (we) begin
      wbcount_reg <= wbcount_reg + 32'd1;
    end
  end

  // Read ports follow three rules in order. Index 0 reads as zero. An index
  // matching the write in flight returns wbdata. Any other index reads the array.
  always_comb begin
    rd1_next = '0;
    if (bus.readreg1_in != '0) begin
      if (we && (bus.readreg1_in == bus.writeregister_in)) begin
        rd1_next = wbdata;
      end else begin
        rd1_next = regs_reg[bus.readreg1_in];
      end
    end
  end

  always_comb begin
    rd2_next = '0;
    if (bus.readreg2_in != '0) begin
      if (we && (bus.readreg2_in == bus.writeregister_in)) begin
        rd2_next = wbdata;
      end else begin
        rd2_next = regs_reg[bus.readreg2_in];
      end
    end
  end

  assign bus.readdata1_out = rd1_next;
  assign bus.readdata2_out = rd2_next;
  assign bus.wbdata_out    = wbdata;
  assign bus.wbcount_out   = wbcount_reg;
endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Wait for the next rising edge, then let the outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic m2r,
                    input logic [31:0] mem, input logic [31:0] alu);
    bus.regwrite_in      = 1'b1;
    bus.writeregister_in = idx;
    bus.memtoreg_in      = m2r;
    bus.memres_in        = mem;
    bus.alures_in        = alu;
  endtask

  task automatic idle();
    bus.regwrite_in = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    bus.readreg1_in = a;
    bus.readreg2_in = b;
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    bus.regwrite_in = 1'b0; bus.memtoreg_in = 1'b0;
    bus.memres_in = '0; bus.alures_in = '0;
    bus.writeregister_in = '0; bus.readreg1_in = '0; bus.readreg2_in = '0;
    tick(); tick();
    $display("[TB] initial reset");
    rd(5'd1, 5'd31);
    check("rst_rd1", bus.readdata1_out, 32'h0);
    check("rst_rd2", bus.readdata2_out, 32'h0);
    check("rst_count", bus.wbcount_out, 32'h0);
    reset_n = 1'b1;

    // Preload r5, then apply reset while a write to r7 is presented.
    wr(5'd5, 1'b0, 32'h0, 32'h1234); tick(); idle();
    rd(5'd5, 5'd0);
    $display("[TB] write r5=00001234 -> %08h", bus.readdata1_out);
    check("preload_r5", bus.readdata1_out, 32'h1234);
    check("preload_count", bus.wbcount_out, 32'd1);
    reset_n = 1'b0;
    wr(5'd7, 1'b0, 32'h0, 32'hAA); tick();
    reset_n = 1'b1; idle();
    rd(5'd5, 5'd7);
    $display("[TB] reset with r7 write: r5=%08h r7=%08h", bus.readdata1_out, bus.readdata2_out);
    check("reset_r5", bus.readdata1_out, 32'h0);
    check("reset_r7_dropped", bus.readdata2_out, 32'h0);
    check("reset_count", bus.wbcount_out, 32'h0);

    // Writeback select and commit.
    wr(5'd3, 1'b1, 32'hDEADBEEF, 32'h11111111); #1;
    check("sel_mem_wbdata", bus.wbdata_out, 32'hDEADBEEF);
    tick();
    wr(5'd4, 1'b0, 32'hDEADBEEF, 32'h11111111); #1;
    check("sel_alu_wbdata", bus.wbdata_out, 32'h11111111);
    tick(); idle();
    rd(5'd3, 5'd4);
    $display("[TB] r3=%08h r4=%08h count=%0d", bus.readdata1_out, bus.readdata2_out, bus.wbcount_out);
    check("commit_r3", bus.readdata1_out, 32'hDEADBEEF);
    check("commit_r4", bus.readdata2_out, 32'h11111111);
    check("commit_count", bus.wbcount_out, 32'd2);

    // Bypass on both ports in the same cycle.
    wr(5'd9, 1'b0, 32'h0, 32'h5); tick(); idle();
    rd(5'd9, 5'd9);
    check("bypass_pre_r9", bus.readdata1_out, 32'h5);
    wr(5'd9, 1'b1, 32'h77, 32'h0); rd(5'd9, 5'd9);
    $display("[TB] bypass r9=77 before edge: %08h %08h", bus.readdata1_out, bus.readdata2_out);
    check("bypass_rd1", bus.readdata1_out, 32'h77);
    check("bypass_rd2", bus.readdata2_out, 32'h77);
    tick(); idle(); #1;
    check("bypass_after_rd1", bus.readdata1_out, 32'h77);
    check("bypass_after_rd2", bus.readdata2_out, 32'h77);
    check("bypass_count", bus.wbcount_out, 32'd4);

    // r0 protection.
    wr(5'd0, 1'b0, 32'h0, 32'hFFFFFFFF); rd(5'd0, 5'd0);
    $display("[TB] write r0 attempt: rd1=%08h", bus.readdata1_out);
    check("r0_pre", bus.readdata1_out, 32'h0);
    tick(); idle(); #1;
    check("r0_post", bus.readdata1_out, 32'h0);
    check("r0_count", bus.wbcount_out, 32'd4);

    // Disabled write, then an X index with regwrite low.
    wr(5'd6, 1'b0, 32'h0, 32'h66); tick();
    bus.regwrite_in = 1'b0; bus.writeregister_in = 5'd6; bus.alures_in = 32'h99;
    rd(5'd6, 5'd9);
    $display("[TB] disabled write r6=99: rd1=%08h", bus.readdata1_out);
    check("dis_pre_r6", bus.readdata1_out, 32'h66);
    tick();
    check("dis_post_r6", bus.readdata1_out, 32'h66);
    check("dis_count", bus.wbcount_out, 32'd5);
    bus.writeregister_in = 'x; tick();
    bus.writeregister_in = '0; #1;
    $display("[TB] X index with regwrite=0: r6=%08h r9=%08h", bus.readdata1_out, bus.readdata2_out);
    check("xidx_r6", bus.readdata1_out, 32'h66);
    check("xidx_r9", bus.readdata2_out, 32'h77);
    check("xidx_count", bus.wbcount_out, 32'd5);

    // Back-to-back writes to r1..r31 after a fresh reset.
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 1'b0, 32'h0, 32'(i) * 32'h01010101);
      tick();
    end
    idle();
    for (int i = 1; i < 32; i++) begin
      rd(5'(i), 5'(32 - i));
      $display("[TB] read r%0d=%08h r%0d=%08h", i, bus.readdata1_out, 32 - i, bus.readdata2_out);
      check($sformatf("b2b_rd1_r%0d", i), bus.readdata1_out, 32'(i) * 32'h01010101);
      check($sformatf("b2b_rd2_r%0d", 32 - i), bus.readdata2_out, 32'(32 - i) * 32'h01010101);
    end
    check("b2b_count", bus.wbcount_out, 32'd31);

    // Counter wrap.
    force dut.wbcount_reg = 32'hFFFFFFFF;
    #1;
    release dut.wbcount_reg;
    #1;
    check("wrap_pre", bus.wbcount_out, 32'hFFFFFFFF);
    wr(5'd2, 1'b0, 32'h0, 32'hABC); tick(); idle();
    rd(5'd2, 5'd0);
    $display("[TB] wrap write r2=00000abc count=%08h", bus.wbcount_out);
    check("wrap_count", bus.wbcount_out, 32'h0);
    check("wrap_r2", bus.readdata1_out, 32'hABC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
